// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage with optional skid buffer, flush and error tag
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [1:0]        occupancy
);

  // Main register: always drives the downstream side in both modes.
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              main_err_q,   main_err_d;
  logic [1:0]        occ_q,        occ_d;

  logic accept;
  logic deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = main_valid_q && out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_err   = main_valid_q && main_err_q;
  assign occupancy = occ_q;

  // Main register and occupancy update; reset clears payload as well as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      occ_q        <= occ_d;
    end
  end

  if (SKID != 0) begin : g_skid

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              skid_err_q,   skid_err_d;
    logic              in_ready_q;

    // in_ready comes straight from a flop so upstream sees no combinational path.
    assign in_ready = in_ready_q;

    // Next state: flush wins, then delivery (with skid-to-main move), then plain accept.
    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_err_d   = main_err_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_err_d   = skid_err_q;

      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (deliver) begin
        if (skid_valid_q) begin
          // in_ready was low, so nothing can be accepted in this cycle.
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          main_err_d   = skid_err_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_err_d   = in_err;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (!main_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_err_d   = in_err;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_err_d   = in_err;
        end
      end

      occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // Skid register plus the registered ready flag, which tracks an empty skid slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
        skid_err_q   <= 1'b0;
        in_ready_q   <= 1'b1;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
        skid_err_q   <= skid_err_d;
        in_ready_q   <= !skid_valid_d;
      end
    end

  end else begin : g_single

    // Ready whenever the single slot is free or is being drained this cycle.
    assign in_ready = !main_valid_q || out_ready;

    // Next state for the single register: flush, then accept, then drain.
    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_err_d   = main_err_q;

      if (flush) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_err_d   = in_err;
      end else if (deliver) begin
        main_valid_d = 1'b0;
      end

      occ_d = {1'b0, main_valid_d};
    end

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table, hand sequences and random model check for pipe_stage_reg
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // SKID=1 instance, 16-bit payload
  logic        iv1 = 0, ie1 = 0, fl1 = 0, ordy1 = 0;
  logic [15:0] id1 = '0;
  logic        ird1, ov1, oe1;
  logic [15:0] od1;
  logic [1:0]  occ1;

  // SKID=0 instance, 8-bit payload
  logic        iv0 = 0, ie0 = 0, fl0 = 0, ordy0 = 0;
  logic [7:0]  id0 = '0;
  logic        ird0, ov0, oe0;
  logic [7:0]  od0;
  logic [1:0]  occ0;

  pipe_stage_reg #(.DATA_W(16), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ird1), .in_data(id1), .in_err(ie1),
    .flush(fl1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_err(oe1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(8), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ird0), .in_data(id0), .in_err(ie0),
    .flush(fl0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_err(oe0),
    .occupancy(occ0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic        rst, flush, iv;
    logic [15:0] id;
    logic        ie, ordy;
    logic        ov;
    logic [15:0] od;
    logic        oe;
    logic [1:0]  occ;
    logic        ird;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic v, logic [15:0] d, logic e, logic o,
                              logic xov, logic [15:0] xod, logic xoe, logic [1:0] xocc, logic xird);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.id = d; t.ie = e; t.ordy = o;
    t.ov = xov; t.od = xod; t.oe = xoe; t.occ = xocc; t.ird = xird;
    return t;
  endfunction

  // behavioural references: FIFO of {err,data} with capacity 2 (skid) or 1 (single)
  logic [16:0] q1[$];
  logic [15:0] last1;
  logic [8:0]  q0[$];
  logic [7:0]  last0;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // rst flush iv id err ordy | ov od oe occ ird
    tbl.push_back(mk(1,0,0,16'h0000,0,0, 0,16'h0000,0,0,1));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,0,1,16'(k),0,1, 1,16'(k),0,1,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h0008,0,0,1));
    // backpressure into the skid slot
    tbl.push_back(mk(0,0,1,16'h00A1,0,1, 1,16'h00A1,0,1,1));
    tbl.push_back(mk(0,0,1,16'h00A2,0,0, 1,16'h00A1,0,2,0));
    tbl.push_back(mk(0,0,1,16'h00A3,0,0, 1,16'h00A1,0,2,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 1,16'h00A2,0,1,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h00A2,0,0,1));
    // error tagging
    tbl.push_back(mk(0,0,1,16'h00C4,1,0, 1,16'h00C4,1,1,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h00C4,0,0,1));
    // flush with occupancy 2 and a beat offered
    tbl.push_back(mk(0,0,1,16'h00B1,0,0, 1,16'h00B1,0,1,1));
    tbl.push_back(mk(0,0,1,16'h00B2,0,0, 1,16'h00B1,0,2,0));
    tbl.push_back(mk(0,1,1,16'h00B3,0,0, 0,16'h00B1,0,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h00B1,0,0,1));
    tbl.push_back(mk(0,0,1,16'h00B4,0,1, 1,16'h00B4,0,1,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h00B4,0,0,1));
    // reset over flush mid-stall, then resume
    tbl.push_back(mk(0,0,1,16'h00D1,1,0, 1,16'h00D1,1,1,1));
    tbl.push_back(mk(0,0,1,16'h00D2,0,0, 1,16'h00D1,1,2,0));
    tbl.push_back(mk(1,1,1,16'h00D3,1,0, 0,16'h0000,0,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h0000,0,0,1));
    tbl.push_back(mk(0,0,1,16'h00E1,0,1, 1,16'h00E1,0,1,1));
    tbl.push_back(mk(0,0,1,16'h00E2,0,1, 1,16'h00E2,0,1,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,1, 0,16'h00E2,0,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; fl1 = tbl[i].flush; iv1 = tbl[i].iv;
      id1 = tbl[i].id;  ie1 = tbl[i].ie;    ordy1 = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(ov1),  32'(tbl[i].ov));
      chk($sformatf("vec%0d out_data", i),  32'(od1),  32'(tbl[i].od));
      chk($sformatf("vec%0d out_err", i),   32'(oe1),  32'(tbl[i].oe));
      chk($sformatf("vec%0d occupancy", i), 32'(occ1), 32'(tbl[i].occ));
      chk($sformatf("vec%0d in_ready", i),  32'(ird1), 32'(tbl[i].ird));
    end
    rst = 0; fl1 = 0; iv1 = 0; ie1 = 0; ordy1 = 0;

    // single-register mode: stall blocks input, then same-cycle accept and deliver
    chk("s0 reset in_ready", 32'(ird0), 32'd1);
    chk("s0 reset out_valid", 32'(ov0), 32'd0);
    iv0 = 1; id0 = 8'h41; ie0 = 1; ordy0 = 0;
    @(posedge clk); #1;
    chk("s0 load out_valid", 32'(ov0), 32'd1);
    chk("s0 load out_data", 32'(od0), 32'h41);
    chk("s0 load out_err", 32'(oe0), 32'd1);
    id0 = 8'h42; ie0 = 0; #1;
    chk("s0 stall in_ready", 32'(ird0), 32'd0);
    @(posedge clk); #1;
    chk("s0 stall out_data", 32'(od0), 32'h41);
    chk("s0 stall occupancy", 32'(occ0), 32'd1);
    ordy0 = 1; id0 = 8'h43; #1;
    chk("s0 pass in_ready", 32'(ird0), 32'd1);
    @(posedge clk); #1;
    chk("s0 pass out_data", 32'(od0), 32'h43);
    chk("s0 pass occupancy", 32'(occ0), 32'd1);
    chk("s0 pass out_err", 32'(oe0), 32'd0);
    iv0 = 0;
    @(posedge clk); #1;
    chk("s0 drain out_valid", 32'(ov0), 32'd0);
    chk("s0 drain out_data hold", 32'(od0), 32'h43);

    // randomized run of both instances against the FIFO models
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q1 = {}; q0 = {}; last1 = '0; last0 = '0;
    for (int c = 0; c < 3000; c++) begin
      logic acc1, del1, acc0, del0;
      chk("rnd1 out_valid", 32'(ov1), 32'(q1.size() > 0));
      chk("rnd1 out_data", 32'(od1), 32'(q1.size() > 0 ? q1[0][15:0] : last1));
      chk("rnd1 out_err", 32'(oe1), 32'(q1.size() > 0 ? q1[0][16] : 1'b0));
      chk("rnd1 occupancy", 32'(occ1), 32'(q1.size()));
      chk("rnd1 in_ready", 32'(ird1), 32'(q1.size() < 2));
      chk("rnd0 out_valid", 32'(ov0), 32'(q0.size() > 0));
      chk("rnd0 out_data", 32'(od0), 32'(q0.size() > 0 ? q0[0][7:0] : last0));
      chk("rnd0 out_err", 32'(oe0), 32'(q0.size() > 0 ? q0[0][8] : 1'b0));
      chk("rnd0 occupancy", 32'(occ0), 32'(q0.size()));

      rst   = ($urandom_range(0, 59) == 0);
      fl1   = ($urandom_range(0, 11) == 0);
      fl0   = ($urandom_range(0, 11) == 0);
      iv1   = ($urandom_range(0, 3) != 0);
      iv0   = ($urandom_range(0, 3) != 0);
      ordy1 = ($urandom_range(0, 2) != 0);
      ordy0 = ($urandom_range(0, 2) != 0);
      id1   = 16'($urandom);
      id0   = 8'($urandom);
      ie1   = ($urandom_range(0, 4) == 0);
      ie0   = ($urandom_range(0, 4) == 0);
      #1;
      chk("rnd0 in_ready", 32'(ird0), 32'((q0.size() == 0) || ordy0));

      acc1 = iv1 && (q1.size() < 2);
      del1 = (q1.size() > 0) && ordy1;
      acc0 = iv0 && ((q0.size() == 0) || ordy0);
      del0 = (q0.size() > 0) && ordy0;
      @(posedge clk);
      if (rst) begin
        q1 = {}; q0 = {}; last1 = '0; last0 = '0;
      end else begin
        if (fl1) q1 = {};
        else begin
          if (del1) void'(q1.pop_front());
          if (acc1) q1.push_back({ie1, id1});
        end
        if (fl0) q0 = {};
        else begin
          if (del0) void'(q0.pop_front());
          if (acc0) q0.push_back({ie0, id0});
        end
      end
      if (q1.size() > 0) last1 = q1[0][15:0];
      if (q0.size() > 0) last0 = q0[0][7:0];
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
